spi_frame_ctrl: RTL and testbench
=================================

Name: spi_frame_ctrl

Overview:
- SPI slave front end that feeds the serial register bank.
- Synchronises an external SPI link (mode 0, MSB first) into the `clk` domain and deframes 40-bit transactions: 8-bit address byte, then 32-bit data word.
- Write frames produce a single-cycle write strobe on `adr[7]` with `adr[6:0]` and `data_wr` held stable.
- Read frames present the address, capture the bank's combinational `data_rd` and shift it out on MISO during the data phase.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on `spi_sck`, `spi_cs_n` and `spi_mosi`; legal range 2–3.
- ERRCNT_W, 16: width of the aborted-frame counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- spi_sck  in  1  SPI clock, asynchronous to `clk`, frequency ≤ clk/8
- spi_cs_n  in  1  SPI chip select, active low
- spi_mosi  in  1  serial data from host
- spi_miso  out  1  serial data to host
- spi_miso_oe  out  1  MISO output enable; 1 while CS is asserted (synchronised)
- adr  out  8  to register bank: [6:0] register address, [7] write strobe
- data_wr  out  32  write data to register bank
- data_rd  in  32  read data from register bank, combinational from `adr[6:0]`
- busy  out  1  high from frame start until return to IDLE
- frame_err_cnt  out  ERRCNT_W  aborted-frame count (see Optional Feature)

Behaviour:
- Reset values: `adr`=0, `data_wr`=0, `spi_miso`=0, `spi_miso_oe`=0, `busy`=0, `frame_err_cnt`=0. Reset clears the FSM to IDLE and clears both shift registers and the bit counter.
- Inputs pass through SYNC_STAGES flops. Edge detect on the synchronised `spi_sck`:
  - rise: sample MOSI.
  - fall: update MISO.
- Bit counter is 6 bits, range 0..40. Shift-in register is 8 bits for the address and 32 bits for data.
- FSM states:
  - IDLE: wait for synchronised `spi_cs_n`=0 → ADDR. Set `busy`=1, clear the counter.
  - ADDR: on each sck rise shift MOSI into the address register. On the 8th rise:
    - latch `adr[6:0]` and the write flag (first bit received); keep `adr[7]`=0;
    - → RDLOAD.
  - RDLOAD: one cycle; `tx_shift` ← `data_rd` (valid for reads; harmless for writes) → DATA.
  - DATA, read frame (write flag = 0): on each sck fall drive `spi_miso` ← `tx_shift[31]`, then shift left. The first fall after the 8th rise outputs bit 31.
  - DATA, all frames: on each sck rise shift MOSI into `rx_shift`. On the 40th rise → COMMIT.
  - COMMIT: one cycle.
    - Write frame: `data_wr` ← `rx_shift` and `adr[7]`=1 for exactly this cycle.
    - Read frame: no strobe, `data_wr` unchanged.
    - → DONE.
  - DONE: `adr[7]`=0; `adr[6:0]` and `data_wr` hold. Ignore further sck edges; `spi_miso` holds the last bit. On CS deassert → IDLE, `busy`=0.
- `adr[6:0]` and `data_wr` hold their last values in IDLE until the next frame's address/commit.
- CS deassert in ADDR, RDLOAD or DATA:
  - → IDLE immediately, no strobe, `data_wr` unchanged;
  - the abort is counted (see Optional Feature).
- CS deassert and the 40th sck rise in the same `clk` cycle: the frame counts as aborted and no strobe is issued.
- More than 40 bits in one frame: extra bits are ignored with no second strobe.
- `spi_miso_oe` follows the synchronised `~spi_cs_n`. `spi_miso` returns to 0 in IDLE.
- Consecutive frames: CS high for ≥ SYNC_STAGES+2 `clk` cycles is required between frames.

Optional Feature:
- Macro: SPI_FRAME_ERRCNT_EN.
- Defined: `frame_err_cnt` increments by 1 on each aborted frame and saturates at all-ones (no wrap). It is cleared only by reset.
- Undefined: `frame_err_cnt` is tied to 0 and no counter logic is built.

Test Plan:
- Write frame, address byte 0x86, data 0xDEADBEEF → after CS low:
  - exactly one `clk` with `adr`=0x86 and `data_wr`=0xDEADBEEF;
  - then `adr`=0x06 holds;
  - `busy` falls after CS high.
- Read frame, address 0x07, bank returns 0x12345678 for address 7 → host samples 0x12345678 on MISO (MSB first) over 32 data clocks; `adr`=0x07, no strobe, `data_wr` unchanged.
- Abort: write 0x81, CS raised after 20 bits →
  - no strobe, `data_wr` unchanged;
  - `frame_err_cnt`=1 with SPI_FRAME_ERRCNT_EN, 0 without;
  - next full write 0x81/0x00000001 commits normally.
- 44-bit write frame 0x82/0xA5A5A5A5 plus 4 extra bits → exactly one strobe, `data_wr`=0xA5A5A5A5.
- `rstn` asserted mid data phase → all outputs at reset values immediately. After release, a new read of 0x00 returns the bank's value correctly.
- With SPI_FRAME_ERRCNT_EN and ERRCNT_W=4, issue 17 aborts → `frame_err_cnt` saturates at 0xF.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spi_frame_ctrl
//
// SPI slave front end for the serial register bank. The external SPI link is
// mode 0 with MSB first. It is synchronised into the clk domain and deframed
// into 40-bit transactions: one address byte followed by one 32-bit data word.
//
// Address byte layout: bit 7 is the write flag (the first bit received), and
// bits 6:0 are the register address.
//
// Write frames: at commit, adr[7] pulses high for one clk with adr[6:0] and
// data_wr stable.
// Read frames: adr[6:0] is presented, the combinational data_rd is captured,
// and that word is shifted out on MISO during the data phase.
//
// Parameters
//   SYNC_STAGES : flops on spi_sck / spi_cs_n / spi_mosi (2..3)
//   ERRCNT_W    : width of the aborted-frame counter
//
// Optional feature macro: SPI_FRAME_ERRCNT_EN
//   defined   -> frame_err_cnt counts aborted frames, saturating at all-ones
//   undefined -> frame_err_cnt tied to zero, no counter logic
//
// Ports
//   clk           in   system clock
//   rstn          in   asynchronous active-low reset
//   spi_sck       in   SPI clock (async, <= clk/8)
//   spi_cs_n      in   SPI chip select, active low
//   spi_mosi      in   serial data from host
//   spi_miso      out  serial data to host
//   spi_miso_oe   out  MISO output enable (synchronised ~spi_cs_n)
//   adr[7:0]      out  [6:0] register address, [7] write strobe
//   data_wr[31:0] out  write data to register bank
//   data_rd[31:0] in   read data from register bank (combinational on adr)
//   busy          out  high from frame start until return to idle
//   frame_err_cnt out  aborted-frame count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_frame_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int ERRCNT_W    = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                spi_sck,
    input  logic                spi_cs_n,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    output logic [7:0]          adr,
    output logic [31:0]         data_wr,
    input  logic [31:0]         data_rd,
    output logic                busy,
    output logic [ERRCNT_W-1:0] frame_err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_RDLOAD = 3'd2,
        ST_DATA   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Synchroniser chains; chip select resets to the inactive level so the
    // FSM cannot see a phantom frame start on reset release.
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] cs_n_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_prev_r;

    logic sck_s;
    logic cs_active_s;
    logic mosi_s;
    logic sck_rise_s;
    logic sck_fall_s;

    state_t      state_r,      state_n;
    logic [5:0]  bit_cnt_r,    bit_cnt_n;
    logic [7:0]  addr_shift_r, addr_shift_n;
    logic [31:0] rx_shift_r,   rx_shift_n;
    logic [31:0] tx_shift_r,   tx_shift_n;
    logic        wr_flag_r,    wr_flag_n;
    logic [7:0]  adr_r,        adr_n;
    logic [31:0] data_wr_r,    data_wr_n;
    logic        miso_r,       miso_n;
    logic        miso_oe_r,    miso_oe_n;
    logic        busy_r,       busy_n;

    // Input synchronisers and previous-sck register for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            cs_n_sync_r <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_prev_r  <= 1'b0;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
            cs_n_sync_r <= {cs_n_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_r  <= sck_sync_r[SYNC_STAGES-1];
        end
    end

    assign sck_s       = sck_sync_r[SYNC_STAGES-1];
    assign cs_active_s = ~cs_n_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s  = sck_s & ~sck_prev_r;
    assign sck_fall_s  = ~sck_s & sck_prev_r;

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 6'd0;
            addr_shift_r <= 8'd0;
            rx_shift_r   <= 32'd0;
            tx_shift_r   <= 32'd0;
            wr_flag_r    <= 1'b0;
            adr_r        <= 8'd0;
            data_wr_r    <= 32'd0;
            miso_r       <= 1'b0;
            miso_oe_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            bit_cnt_r    <= bit_cnt_n;
            addr_shift_r <= addr_shift_n;
            rx_shift_r   <= rx_shift_n;
            tx_shift_r   <= tx_shift_n;
            wr_flag_r    <= wr_flag_n;
            adr_r        <= adr_n;
            data_wr_r    <= data_wr_n;
            miso_r       <= miso_n;
            miso_oe_r    <= miso_oe_n;
            busy_r       <= busy_n;
        end
    end

    // Next-state and next-output logic. Chip-select loss is checked before
    // any sck edge, so CS rising together with the 40th sck rise is an abort.
    always_comb begin
        state_n      = state_r;
        bit_cnt_n    = bit_cnt_r;
        addr_shift_n = addr_shift_r;
        rx_shift_n   = rx_shift_r;
        tx_shift_n   = tx_shift_r;
        wr_flag_n    = wr_flag_r;
        adr_n        = {1'b0, adr_r[6:0]};
        data_wr_n    = data_wr_r;
        miso_n       = miso_r;
        miso_oe_n    = cs_active_s;
        busy_n       = busy_r;

        case (state_r)
            ST_IDLE: begin
                miso_n = 1'b0;
                if (cs_active_s) begin
                    state_n      = ST_ADDR;
                    busy_n       = 1'b1;
                    bit_cnt_n    = 6'd0;
                    addr_shift_n = 8'd0;
                    rx_shift_n   = 32'd0;
                    wr_flag_n    = 1'b0;
                end else begin
                    busy_n = 1'b0;
                end
            end

            ST_ADDR: begin
                if (!cs_active_s) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    miso_n  = 1'b0;
                end else if (sck_rise_s) begin
                    addr_shift_n = {addr_shift_r[6:0], mosi_s};
                    bit_cnt_n    = bit_cnt_r + 6'd1;
                    if (bit_cnt_r == 6'd7) begin
                        // First bit received is now at addr_shift_r[6].
                        wr_flag_n = addr_shift_r[6];
                        adr_n     = {1'b0, addr_shift_r[5:0], mosi_s};
                        state_n   = ST_RDLOAD;
                    end else begin
                        state_n = ST_ADDR;
                    end
                end else begin
                    state_n = ST_ADDR;
                end
            end

            ST_RDLOAD: begin
                if (!cs_active_s) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    miso_n  = 1'b0;
                end else begin
                    // adr_r already carries the new address, so data_rd is valid.
                    tx_shift_n = data_rd;
                    state_n    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (!cs_active_s) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    miso_n  = 1'b0;
                end else begin
                    if (sck_fall_s && !wr_flag_r) begin
                        miso_n     = tx_shift_r[31];
                        tx_shift_n = {tx_shift_r[30:0], 1'b0};
                    end else begin
                        tx_shift_n = tx_shift_r;
                    end
                    if (sck_rise_s) begin
                        rx_shift_n = {rx_shift_r[30:0], mosi_s};
                        bit_cnt_n  = bit_cnt_r + 6'd1;
                        if (bit_cnt_r == 6'd39) begin
                            state_n = ST_COMMIT;
                        end else begin
                            state_n = ST_DATA;
                        end
                    end else begin
                        state_n = ST_DATA;
                    end
                end
            end

            ST_COMMIT: begin
                if (wr_flag_r) begin
                    data_wr_n = rx_shift_r;
                    adr_n     = {1'b1, adr_r[6:0]};
                end else begin
                    data_wr_n = data_wr_r;
                end
                state_n = ST_DONE;
            end

            ST_DONE: begin
                // Further sck edges are ignored; MISO holds its last bit.
                if (!cs_active_s) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    miso_n  = 1'b0;
                end else begin
                    state_n = ST_DONE;
                end
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
                miso_n  = 1'b0;
            end
        endcase
    end

`ifdef SPI_FRAME_ERRCNT_EN
    logic                abort_s;
    logic [ERRCNT_W-1:0] err_cnt_r;

    assign abort_s = ~cs_active_s &
                     ((state_r == ST_ADDR) || (state_r == ST_RDLOAD) || (state_r == ST_DATA));

    // Saturating aborted-frame counter, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_r <= {ERRCNT_W{1'b0}};
        end else if (abort_s && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign frame_err_cnt = err_cnt_r;
`else
    assign frame_err_cnt = {ERRCNT_W{1'b0}};
`endif

    assign spi_miso    = miso_r;
    assign spi_miso_oe = miso_oe_r;
    assign adr         = adr_r;
    assign data_wr     = data_wr_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
`timescale 1ns/1ps

module tb_spi_frame_ctrl;

    localparam int HALF = 50;   // SPI half period: 5 clk periods
    localparam int GAP  = 100;  // CS-high settle time between frames

    logic        clk;
    logic        rstn;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [7:0]  adr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        busy;
    logic [3:0]  frame_err_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [6:0]  exp_adr       = 7'd0;
    logic [31:0] exp_data_wr   = 32'd0;
    logic [3:0]  exp_err       = 4'd0;
    logic        strobe_expect = 1'b0;
    logic [6:0]  strobe_adr    = 7'd0;
    logic [31:0] strobe_data   = 32'd0;
    int          strobe_cnt    = 0;
    logic        check_en      = 1'b0;

    spi_frame_ctrl #(.SYNC_STAGES(2), .ERRCNT_W(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .spi_sck       (spi_sck),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .adr           (adr),
        .data_wr       (data_wr),
        .data_rd       (data_rd),
        .busy          (busy),
        .frame_err_cnt (frame_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank contents seen by the DUT
    function automatic logic [31:0] bank(input logic [6:0] a);
        if (a == 7'd7) bank = 32'h12345678;
        else           bank = {1'b0, a, 24'h5AC3E1};
    endfunction

    assign data_rd = bank(adr[6:0]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] err_after_abort(input logic [3:0] e);
`ifdef SPI_FRAME_ERRCNT_EN
        err_after_abort = (e == 4'hF) ? 4'hF : e + 4'd1;
`else
        err_after_abort = 4'd0;
`endif
    endfunction

    // Compare process: strobe monitor and idle-state check against the model
    always @(negedge clk) begin
        if (rstn && adr[7]) begin
            strobe_cnt <= strobe_cnt + 1;
            chk("strobe_expected", {63'd0, strobe_expect}, 64'd1);
            chk("strobe_adr", {56'd0, adr}, {56'd0, 1'b1, strobe_adr});
            chk("strobe_data", {32'd0, data_wr}, {32'd0, strobe_data});
        end
        if (check_en) begin
            chk("idle_adr", {56'd0, adr}, {56'd0, 1'b0, exp_adr});
            chk("idle_data_wr", {32'd0, data_wr}, {32'd0, exp_data_wr});
            chk("idle_busy", {63'd0, busy}, 64'd0);
            chk("idle_miso", {63'd0, spi_miso}, 64'd0);
            chk("idle_miso_oe", {63'd0, spi_miso_oe}, 64'd0);
            chk("idle_err_cnt", {60'd0, frame_err_cnt}, {60'd0, exp_err});
        end
    end

    // Host-side SPI transfer. frame holds nbits, first-sent bit at [nbits-1].
    // cs_on_last raises CS together with the last sck rise; rst_bit >= 0
    // asserts rstn just before that bit's rising edge.
    task automatic spi_xfer(input logic [63:0] frame, input int nbits,
                            input bit cs_on_last, input int rst_bit,
                            output logic [31:0] rd_word);
        logic [63:0] tmp;
        logic [6:0]  a;
        logic [31:0] d;
        logic        is_wr;
        bit          aborted;
        int          cnt0;

        check_en = 1'b0;
        is_wr    = frame[nbits-1];
        tmp      = frame >> (nbits - 8);
        a        = tmp[6:0];
        d        = 32'd0;
        if (nbits >= 40) begin
            tmp = frame >> (nbits - 40);
            d   = tmp[31:0];
        end
        aborted       = (nbits < 40) || (cs_on_last && nbits == 40) || (rst_bit >= 0);
        strobe_expect = !aborted && is_wr;
        strobe_adr    = a;
        strobe_data   = d;
        cnt0          = strobe_cnt;
        rd_word       = 32'd0;

        @(negedge clk);
        spi_cs_n = 1'b0;
        #HALF;
        chk("frame_busy", {63'd0, busy}, 64'd1);
        chk("frame_miso_oe", {63'd0, spi_miso_oe}, 64'd1);

        for (int i = 0; i < nbits; i++) begin
            spi_mosi = frame[nbits-1-i];
            if (i == rst_bit) begin
                rstn = 1'b0;
                #1;
                chk("rst_adr", {56'd0, adr}, 64'd0);
                chk("rst_data_wr", {32'd0, data_wr}, 64'd0);
                chk("rst_miso", {63'd0, spi_miso}, 64'd0);
                chk("rst_miso_oe", {63'd0, spi_miso_oe}, 64'd0);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_err_cnt", {60'd0, frame_err_cnt}, 64'd0);
                spi_cs_n      = 1'b1;
                spi_mosi      = 1'b0;
                strobe_expect = 1'b0;
                exp_adr       = 7'd0;
                exp_data_wr   = 32'd0;
                exp_err       = 4'd0;
                #GAP;
                rstn = 1'b1;
                #GAP;
                chk("rst_no_strobe", 64'(strobe_cnt - cnt0), 64'd0);
                check_en = 1'b1;
                repeat (3) @(negedge clk);
                return;
            end
            #HALF;
            spi_sck = 1'b1;
            if (cs_on_last && i == nbits - 1) spi_cs_n = 1'b1;
            if (i >= 8 && i < 40) rd_word = {rd_word[30:0], spi_miso};
            #HALF;
            spi_sck = 1'b0;
        end
        spi_mosi = 1'b0;
        if (!cs_on_last) begin
            #HALF;
            spi_cs_n = 1'b1;
        end
        #GAP;

        chk("strobe_count", 64'(strobe_cnt - cnt0), strobe_expect ? 64'd1 : 64'd0);
        if (nbits >= 8) exp_adr = a;
        if (!aborted && is_wr) exp_data_wr = d;
        if (aborted) exp_err = err_after_abort(exp_err);
        strobe_expect = 1'b0;
        check_en      = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Bounded run time
    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rw;

        rstn     = 1'b0;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_adr", {56'd0, adr}, 64'd0);
        chk("reset_data_wr", {32'd0, data_wr}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_miso_oe", {63'd0, spi_miso_oe}, 64'd0);
        chk("reset_err_cnt", {60'd0, frame_err_cnt}, 64'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_en = 1'b1;
        repeat (3) @(negedge clk);

        // Write 0x86 / 0xDEADBEEF
        spi_xfer({24'd0, 8'h86, 32'hDEADBEEF}, 40, 1'b0, -1, rw);
        chk("wr1_data_wr", {32'd0, data_wr}, 64'hDEADBEEF);
        chk("wr1_adr", {56'd0, adr}, 64'h06);

        // Read 0x07
        spi_xfer({24'd0, 8'h07, 32'h0}, 40, 1'b0, -1, rw);
        chk("rd7_miso_word", {32'd0, rw}, 64'h12345678);
        chk("rd7_model_word", {32'd0, rw}, {32'd0, bank(7'd7)});
        chk("rd7_adr", {56'd0, adr}, 64'h07);
        chk("rd7_data_wr", {32'd0, data_wr}, 64'hDEADBEEF);

        // Abort a write 0x81 after 20 bits
        spi_xfer({24'd0, 8'h81, 32'h89ABCDEF} >> 20, 20, 1'b0, -1, rw);
        chk("abort_data_wr", {32'd0, data_wr}, 64'hDEADBEEF);
`ifdef SPI_FRAME_ERRCNT_EN
        chk("abort_err_cnt", {60'd0, frame_err_cnt}, 64'd1);
`else
        chk("abort_err_cnt", {60'd0, frame_err_cnt}, 64'd0);
`endif

        // Full write 0x81 / 0x00000001 after the abort
        spi_xfer({24'd0, 8'h81, 32'h00000001}, 40, 1'b0, -1, rw);
        chk("wr2_data_wr", {32'd0, data_wr}, 64'h1);
        chk("wr2_adr", {56'd0, adr}, 64'h01);

        // 44-bit write 0x82 / 0xA5A5A5A5 plus 4 extra bits
        spi_xfer({20'd0, 8'h82, 32'hA5A5A5A5, 4'hF}, 44, 1'b0, -1, rw);
        chk("wr44_data_wr", {32'd0, data_wr}, 64'hA5A5A5A5);
        chk("wr44_adr", {56'd0, adr}, 64'h02);

        // CS rises together with the 40th sck rise: aborted, no strobe
        spi_xfer({24'd0, 8'h83, 32'h11111111}, 40, 1'b1, -1, rw);
        chk("cslast_data_wr", {32'd0, data_wr}, 64'hA5A5A5A5);
        chk("cslast_adr", {56'd0, adr}, 64'h03);
`ifdef SPI_FRAME_ERRCNT_EN
        chk("cslast_err_cnt", {60'd0, frame_err_cnt}, 64'd2);
`else
        chk("cslast_err_cnt", {60'd0, frame_err_cnt}, 64'd0);
`endif

        // Reset during the data phase of a read, then read address 0
        spi_xfer({24'd0, 8'h05, 32'h0}, 40, 1'b0, 20, rw);
        spi_xfer({24'd0, 8'h00, 32'h0}, 40, 1'b0, -1, rw);
        chk("rd0_miso_word", {32'd0, rw}, 64'h005AC3E1);
        chk("rd0_adr", {56'd0, adr}, 64'h0);
        chk("rd0_data_wr", {32'd0, data_wr}, 64'h0);

        // 17 short aborts to drive the counter into saturation
        for (int k = 0; k < 17; k++) begin
            spi_xfer(64'h5, 3, 1'b0, -1, rw);
        end
`ifdef SPI_FRAME_ERRCNT_EN
        chk("sat_err_cnt", {60'd0, frame_err_cnt}, 64'hF);
`else
        chk("sat_err_cnt", {60'd0, frame_err_cnt}, 64'h0);
`endif
        chk("total_strobes", 64'(strobe_cnt), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
